fp_mul_sweep_driver: RTL and testbench

FP_MUL_SWEEP_DRIVER -- requirements
Module: fp_mul_sweep_driver

---
 rtl/fp_mul_sweep_driver.sv | 155 +++++++++++++++
 tb/tb_fp_mul_sweep_driver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_sweep_driver.sv
// Sweeps every operand pair of a fixed special-value table through an external
// FP multiplier and presents each result as a valid/ready record.
// Optional SWEEP_RND_EN: adds an outer loop over rounding modes 0..5.
module fp_mul_sweep_driver #(
    parameter int unsigned SETTLE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [2:0]  rnd,
    input  logic [31:0] z_in,
    input  logic [0:7]  status_in,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [3:0]  res_i,
    output logic [3:0]  res_j,
    output logic [2:0]  res_rnd,
    output logic [31:0] res_z,
    output logic [0:7]  res_status,
    output logic        busy,
    output logic        done,
    output logic [9:0]  vec_count
);

    // state   | meaning
    // IDLE    | waiting for start; done keeps its last value
    // DRIVE   | operands held on a/b while the multiplier settles
    // CAPTURE | z_in/status_in registered into the record
    // EMIT    | record presented until res_ready
    // DONE    | sweep finished, one cycle before returning to IDLE
    typedef enum logic [2:0] {IDLE, DRIVE, CAPTURE, EMIT, DONE} state_t;

    localparam logic [3:0] LAST_IDX   = 4'd11;
    localparam logic [3:0] SETTLE_TC  = 4'(SETTLE - 1);

    state_t      state_q, state_d;
    logic [3:0]  i_q, j_q;
    logic [3:0]  i_nx, j_nx;
    logic [2:0]  rnd_nx;
    logic [3:0]  settle_q;
    logic        start_sweep;
    logic        accept;
    logic        last_vec;

    function automatic logic [31:0] op_word(input logic [3:0] idx);
        case (idx)
            4'd0:    op_word = 32'h7FC00000;
            4'd1:    op_word = 32'hFFC00000;
            4'd2:    op_word = 32'h7FA00000;
            4'd3:    op_word = 32'hFFA00000;
            4'd4:    op_word = 32'h7F800000;
            4'd5:    op_word = 32'hFF800000;
            4'd6:    op_word = 32'h00000000;
            4'd7:    op_word = 32'h80000000;
            4'd8:    op_word = 32'h00400000;
            4'd9:    op_word = 32'h80400000;
            4'd10:   op_word = 32'h3F800000;
            4'd11:   op_word = 32'hBF800000;
            default: op_word = 32'h00000000;
        endcase
    endfunction

    assign j_nx = (j_q == LAST_IDX) ? 4'd0 : j_q + 4'd1;
    assign i_nx = (j_q != LAST_IDX) ? i_q : ((i_q == LAST_IDX) ? 4'd0 : i_q + 4'd1);

`ifdef SWEEP_RND_EN
    assign rnd_nx   = (i_q == LAST_IDX && j_q == LAST_IDX) ? rnd + 3'd1 : rnd;
    assign last_vec = (i_q == LAST_IDX) && (j_q == LAST_IDX) && (rnd == 3'd5);
`else
    assign rnd_nx   = 3'd0;
    assign last_vec = (i_q == LAST_IDX) && (j_q == LAST_IDX);
`endif

    assign accept    = (state_q == EMIT) && res_ready;
    assign res_valid = (state_q == EMIT);
    assign busy      = (state_q == DRIVE) || (state_q == CAPTURE) || (state_q == EMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        start_sweep = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = DRIVE;
                    start_sweep = 1'b1;
                end
            end
            DRIVE:   if (settle_q == 4'd0) state_d = CAPTURE;
            CAPTURE: state_d = EMIT;
            EMIT:    if (res_ready) state_d = last_vec ? DONE : DRIVE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q        <= '0;
            j_q        <= '0;
            rnd        <= '0;
            a          <= '0;
            b          <= '0;
            settle_q   <= '0;
            vec_count  <= '0;
            done       <= 1'b0;
            res_i      <= '0;
            res_j      <= '0;
            res_rnd    <= '0;
            res_z      <= '0;
            res_status <= '0;
        end else begin
            if (start_sweep) begin
                i_q       <= '0;
                j_q       <= '0;
                rnd       <= '0;
                a         <= op_word(4'd0);
                b         <= op_word(4'd0);
                settle_q  <= SETTLE_TC;
                vec_count <= '0;
                done      <= 1'b0;
            end else if (accept) begin
                vec_count <= vec_count + 10'd1;
                if (last_vec) begin
                    done <= 1'b1;
                end else begin
                    // next operands are loaded on the same edge that re-enters DRIVE
                    i_q      <= i_nx;
                    j_q      <= j_nx;
                    rnd      <= rnd_nx;
                    a        <= op_word(i_nx);
                    b        <= op_word(j_nx);
                    settle_q <= SETTLE_TC;
                end
            end else if (state_q == DRIVE && settle_q != 4'd0) begin
                settle_q <= settle_q - 4'd1;
            end

            if (state_q == CAPTURE) begin
                res_z      <= z_in;
                res_status <= status_in;
                res_i      <= i_q;
                res_j      <= j_q;
                res_rnd    <= rnd;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_sweep_driver.sv
// Directed bench for fp_mul_sweep_driver: reset, full sweep with backpressure,
// mid-sweep abort and restart, against a reference operand table.
module tb_fp_mul_sweep_driver;

    localparam int SETTLE = 4;
`ifdef SWEEP_RND_EN
    localparam int N_VEC = 864;
`else
    localparam int N_VEC = 144;
`endif
    localparam int LIMIT = N_VEC * 8 + 100;

    localparam logic [31:0] TBL [12] = '{
        32'h7FC00000, 32'hFFC00000, 32'h7FA00000, 32'hFFA00000,
        32'h7F800000, 32'hFF800000, 32'h00000000, 32'h80000000,
        32'h00400000, 32'h80400000, 32'h3F800000, 32'hBF800000
    };

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a, b;
    logic [2:0]  rnd;
    logic [31:0] z_in;
    logic [0:7]  status_in;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_i, res_j;
    logic [2:0]  res_rnd;
    logic [31:0] res_z;
    logic [0:7]  res_status;
    logic        busy, done;
    logic [9:0]  vec_count;

    int n_checks = 0;
    int n_errors = 0;

    fp_mul_sweep_driver #(.SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(a), .b(b), .rnd(rnd),
        .z_in(z_in), .status_in(status_in),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_i(res_i), .res_j(res_j), .res_rnd(res_rnd),
        .res_z(res_z), .res_status(res_status),
        .busy(busy), .done(done), .vec_count(vec_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // multiplier stand-in: one-cycle registered response
    always @(posedge clk) begin
        z_in      <= a ^ b;
        status_in <= {a[31:28], b[31:28]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_sweep(input int bp, input int abort_at);
        int cycles = 0;
        int nrec = 0;
        int pulses = 0;
        int ei = 0, ej = 0, er = 0;
        logic prev_v = 1'b0;
        bit seen = 1'b0;
        logic [31:0] last_a = '0, last_b = '0;
        logic [31:0] z0, a0, b0;
        logic [3:0]  st_hi;
        @(negedge clk);
        res_ready = (bp == 0);
        start = 1'b1;
        while (cycles < LIMIT) begin
            @(negedge clk);
            cycles++;
            start = (nrec == 5);
            if (res_valid && !prev_v) pulses++;
            prev_v = res_valid;
            if (res_valid && !seen) begin
                seen = 1'b1;
                chk("latency", 32'(cycles), 32'(SETTLE + 2));
                if (bp > 0) begin
                    z0 = res_z; a0 = a; b0 = b;
                    for (int k = 0; k < bp; k++) begin
                        @(negedge clk);
                        cycles++;
                        chk("bp_valid", 32'(res_valid), 32'd1);
                        chk("bp_z", res_z, z0);
                        chk("bp_a", a, a0);
                        chk("bp_b", b, b0);
                    end
                    res_ready = 1'b1;
                end
            end
            if (res_valid && res_ready) begin
                st_hi = TBL[ej][31:28];
                chk("res_i", 32'(res_i), 32'(ei));
                chk("res_j", 32'(res_j), 32'(ej));
                chk("res_rnd", 32'(res_rnd), 32'(er));
                chk("rnd", 32'(rnd), 32'(er));
                chk("a", a, TBL[ei]);
                chk("b", b, TBL[ej]);
                chk("res_z", res_z, TBL[ei] ^ TBL[ej]);
                chk("res_status", 32'(res_status), 32'({TBL[ei][31:28], st_hi}));
                chk("vec_count", 32'(vec_count), 32'(nrec));
                chk("busy", 32'(busy), 32'd1);
                last_a = a;
                last_b = b;
                nrec++;
                if (ej == 11) begin
                    ej = 0;
                    if (ei == 11) begin ei = 0; er++; end
                    else ei++;
                end else ej++;
            end
            if (abort_at >= 0 && int'(vec_count) == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("abort_a", a, 32'd0);
                chk("abort_b", b, 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_vec_count", 32'(vec_count), 32'd0);
                chk("abort_res_z", res_z, 32'd0);
                chk("abort_res_valid", 32'(res_valid), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (done) break;
        end
        start = 1'b0;
        chk("sweep_done", 32'(done), 32'd1);
        chk("pulses", 32'(pulses), 32'(N_VEC));
        chk("records", 32'(nrec), 32'(N_VEC));
        chk("final_vec_count", 32'(vec_count), 32'(N_VEC));
        chk("final_busy", 32'(busy), 32'd0);
        chk("final_res_valid", 32'(res_valid), 32'd0);
        chk("last_a", last_a, 32'hBF800000);
        chk("last_b", last_b, 32'hBF800000);
        repeat (3) @(negedge clk);
        chk("done_sticky", 32'(done), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("hold_a", a, 32'hBF800000);
        chk("hold_b", b, 32'hBF800000);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a", a, 32'd0);
        chk("rst_b", b, 32'd0);
        chk("rst_rnd", 32'(rnd), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_i", 32'(res_i), 32'd0);
        chk("rst_res_j", 32'(res_j), 32'd0);
        chk("rst_res_rnd", 32'(res_rnd), 32'd0);
        chk("rst_res_z", res_z, 32'd0);
        chk("rst_res_status", 32'(res_status), 32'd0);
        chk("rst_vec_count", 32'(vec_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_done", 32'(done), 32'd0);

        run_sweep(10, -1);
        run_sweep(0, 50);
        run_sweep(0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
